// File: rtl/softex_pkg.sv
// Shared types and constants for the softex TCDM responder.
// Holds the grant-policy enum and the LFSR seed.
package softex_pkg;

  typedef enum logic {
    STALL_NONE = 1'b0,
    STALL_LFSR = 1'b1
  } stall_mode_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/softex_tcdm_resp_pipe.sv
// Read-response pipeline: LAT-deep valid/data shift with sync flush.
// Ports: clk_i, rst_i, flush_i, valid_i/data_i in, valid_o/data_o out.
module softex_tcdm_resp_pipe #(
  parameter int DW  = 128,
  parameter int LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic [LAT-1:0] vld_q;
  logic [DW-1:0]  dat_q [LAT];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= valid_i;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Data lanes need no reset: they are masked by the valid bits.
  always_ff @(posedge clk_i) begin
    dat_q[0] <= data_i;
    for (int i = 1; i < LAT; i++) begin
      dat_q[i] <= dat_q[i-1];
    end
  end

  assign valid_o = vld_q[LAT-1];
  assign data_o  = vld_q[LAT-1] ? dat_q[LAT-1] : '0;

endmodule

// File: rtl/softex_tcdm_responder.sv
// TCDM memory responder with byte-enabled writes, pipelined reads,
// optional LFSR grant stalls and a sticky misalignment flag.
// Ports: clk_i, rst_i, clear_i, req_i/gnt_o, add_i, wen_i, be_i,
// data_i, r_data_o, r_valid_o, err_o.
module softex_tcdm_responder
  import softex_pkg::*;
#(
  parameter int          DW         = 128,
  parameter int          AW         = 32,
  parameter int          DEPTH      = 1024,
  parameter int          RD_LATENCY = 1,
  parameter stall_mode_e STALL_MODE = STALL_NONE
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            req_i,
  output logic            gnt_o,
  input  logic [AW-1:0]   add_i,
  input  logic            wen_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [DW-1:0]   data_i,
  output logic [DW-1:0]   r_data_o,
  output logic            r_valid_o,
  output logic            err_o
);

  localparam int NB  = DW / 8;
  localparam int OFS = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);

  logic [15:0]    lfsr_q;
  logic           stall;
  logic           acc;
  logic           rd_acc;
  logic           misal;
  logic [IW-1:0]  idx;
  logic [DW-1:0]  mem [DEPTH];
  logic           unused_hi;

  // Upper address bits are ignored so accesses wrap.
  assign idx       = add_i[OFS +: IW];
  assign unused_hi = ^add_i[AW-1:OFS+IW];
  assign misal     = |add_i[OFS-1:0];

  assign stall  = (STALL_MODE == STALL_LFSR) && (lfsr_q[1:0] == 2'b00);
  assign gnt_o  = req_i && !stall && !rst_i;
  assign acc    = gnt_o;
  assign rd_acc = acc && wen_i && !clear_i;

  // Fibonacci LFSR, taps 16,14,13,11; free-running.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                 lfsr_q[15:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (acc && !wen_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) begin
          mem[idx][8*b +: 8] <= data_i[8*b +: 8];
        end
      end
    end
  end

  // Clear wins over a coincident misaligned access.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      err_o <= 1'b0;
    end else if (acc && misal) begin
      err_o <= 1'b1;
    end
  end

  softex_tcdm_resp_pipe #(
    .DW  (DW),
    .LAT (RD_LATENCY)
  ) u_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (clear_i),
    .valid_i (rd_acc),
    .data_i  (mem[idx]),
    .valid_o (r_valid_o),
    .data_o  (r_data_o)
  );

endmodule

// File: tb/tb_softex_tcdm_responder.sv
// Bench for softex_tcdm_responder: three instances (lat 1, lat 3,
// lat 2 with LFSR stalls) checked each cycle against a reference model.
module tb_softex_tcdm_responder;
  import softex_pkg::*;

  localparam int DW    = 128;
  localparam int AW    = 32;
  localparam int DEPTH = 64;
  localparam int NB    = DW / 8;

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst, clr, req, wen;
  logic [AW-1:0] add;
  logic [NB-1:0] be;
  logic [DW-1:0] wd;

  logic [2:0]    g, rv, er;
  logic [DW-1:0] rd0, rd1, rd2;

  int            lat [3] = '{1, 3, 2};
  logic [DW-1:0] mm [3][DEPTH];
  rsp_t          q [3][$];
  logic [15:0]   m_lfsr;
  logic [2:0]    m_err;
  logic [2:0]    last_acc;
  int            cyc;
  bit            chk_en;
  int            ntests;
  int            nfail;

  always #5 clk = ~clk;

  softex_tcdm_responder #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH),
    .RD_LATENCY(1), .STALL_MODE(STALL_NONE)
  ) u_d0 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .req_i(req),
    .gnt_o(g[0]), .add_i(add), .wen_i(wen), .be_i(be),
    .data_i(wd), .r_data_o(rd0), .r_valid_o(rv[0]), .err_o(er[0])
  );

  softex_tcdm_responder #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH),
    .RD_LATENCY(3), .STALL_MODE(STALL_NONE)
  ) u_d1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .req_i(req),
    .gnt_o(g[1]), .add_i(add), .wen_i(wen), .be_i(be),
    .data_i(wd), .r_data_o(rd1), .r_valid_o(rv[1]), .err_o(er[1])
  );

  softex_tcdm_responder #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH),
    .RD_LATENCY(2), .STALL_MODE(STALL_LFSR)
  ) u_d2 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .req_i(req),
    .gnt_o(g[2]), .add_i(add), .wen_i(wen), .be_i(be),
    .data_i(wd), .r_data_o(rd2), .r_valid_o(rv[2]), .err_o(er[2])
  );

  function automatic logic [DW-1:0] rdk(int k);
    case (k)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  // Expected grant from the spec rule: stall when LFSR low bits are 00.
  function automatic logic egnt(int k);
    logic st;
    st = (k == 2) && (m_lfsr[1:0] == 2'b00);
    return req && !rst && !st;
  endfunction

  task automatic chk(string tag, int k, logic [DW-1:0] obs,
                     logic [DW-1:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s[%0d] cyc %0d: got %h want %h",
             tag, k, cyc, obs, exp);
    end
  endtask

  task automatic check();
    for (int k = 0; k < 3; k++) begin
      logic          ev;
      logic [DW-1:0] ed;
      ev = 1'b0;
      ed = '0;
      if (q[k].size() > 0 && q[k][0].due == cyc) begin
        ev = 1'b1;
        ed = q[k][0].d;
        void'(q[k].pop_front());
      end
      chk("gnt", k, DW'(g[k]), DW'(egnt(k)));
      chk("r_valid", k, DW'(rv[k]), DW'(ev));
      chk("r_data", k, rdk(k), ed);
      chk("err", k, DW'(er[k]), DW'(m_err[k]));
    end
  endtask

  task automatic update();
    for (int k = 0; k < 3; k++) begin
      int   ix;
      logic a;
      a  = egnt(k);
      ix = int'(add[4 +: 6]);
      last_acc[k] = a;
      if (rst) begin
        q[k].delete();
        m_err[k] = 1'b0;
      end else begin
        if (a) begin
          if (add[3:0] != 4'd0) m_err[k] = 1'b1;
          if (!wen) begin
            for (int b = 0; b < NB; b++)
              if (be[b]) mm[k][ix][8*b +: 8] = wd[8*b +: 8];
          end else if (!clr) begin
            q[k].push_back('{cyc + lat[k], mm[k][ix]});
          end
        end
        if (clr) begin
          q[k].delete();
          m_err[k] = 1'b0;
        end
      end
    end
    if (rst) m_lfsr = LFSR_SEED;
    else m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5],
                   m_lfsr[15:1]};
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) check();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic op(logic r, logic w, logic [AW-1:0] a,
                    logic [NB-1:0] b, logic [DW-1:0] d, logic c);
    req = r; wen = w; add = a; be = b; wd = d; clr = c;
    tick();
  endtask

  // Repeat until the stalling instance accepts too.
  task automatic op_all(logic w, logic [AW-1:0] a,
                        logic [NB-1:0] b, logic [DW-1:0] d);
    int n;
    n = 0;
    do begin
      op(1'b1, w, a, b, d, 1'b0);
      n++;
    end while (!last_acc[2] && n < 40);
    ntests++;
    if (!last_acc[2]) begin
      nfail++;
      $error("FAIL grant_timeout cyc %0d: got none want grant", cyc);
    end
  endtask

  task automatic idle(int n);
    repeat (n) op(1'b0, 1'b1, '0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] ones;
    ntests = 0; nfail = 0; cyc = 0; chk_en = 1'b0;
    m_lfsr = LFSR_SEED; m_err = '0; last_acc = '0;
    ones = '1;
    rst = 1'b1; clr = 1'b0; req = 1'b0; wen = 1'b1;
    add = '0; be = '0; wd = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++)
      op_all(1'b0, AW'(i * 16), '1, '0);
    idle(2);

    // Full write then read of word 4.
    op_all(1'b0, 32'h40, '1, {4{32'hDEADBEEF}});
    op_all(1'b1, 32'h40, '0, '0);
    idle(4);

    // Partial byte-enable write over zeros.
    op_all(1'b0, 32'h80, 16'h000F, ones);
    op_all(1'b1, 32'h80, '0, '0);
    idle(4);

    // Address wraps modulo DEPTH.
    op_all(1'b1, 32'h40 + DEPTH * 16, '0, '0);
    idle(4);

    // Back-to-back reads.
    for (int i = 0; i < 8; i++)
      op(1'b1, 1'b1, AW'(i * 16 + 32'h40), '0, '0, 1'b0);
    idle(5);

    // Misaligned read, sticky err, then clear.
    op_all(1'b1, 32'h41, '0, '0);
    idle(4);
    op(1'b0, 1'b1, '0, '0, '0, 1'b1);
    idle(2);

    // Clear with coincident read (dropped) and write (kept).
    op(1'b1, 1'b0, 32'h40, '0, '0, 1'b0);
    op(1'b1, 1'b1, 32'h40, '0, '0, 1'b1);
    op(1'b1, 1'b0, 32'hC0, '1, {4{32'h12345678}}, 1'b1);
    idle(4);
    op_all(1'b1, 32'hC0, '0, '0);
    idle(4);

    // Continuous requests expose the LFSR grant pattern.
    for (int i = 0; i < 40; i++)
      op(1'b1, 1'b1, AW'($urandom_range(0, DEPTH - 1) * 16),
         '0, '0, 1'b0);

    // Reset with reads in flight.
    op(1'b1, 1'b1, 32'h40, '0, '0, 1'b0);
    op(1'b1, 1'b1, 32'h50, '0, '0, 1'b0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(5);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic r, w, c;
      logic [AW-1:0] a;
      r = $urandom_range(0, 3) != 0;
      w = $urandom_range(0, 1) != 0;
      c = !r && ($urandom_range(0, 15) == 0);
      a = $urandom();
      if ($urandom_range(0, 7) != 0) a[3:0] = 4'd0;
      op(r, w, a, NB'($urandom()),
         {$urandom(), $urandom(), $urandom(), $urandom()}, c);
    end
    idle(6);

    for (int k = 0; k < 3; k++)
      chk("drain", k, DW'(q[k].size()), '0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
